// File: rtl/mips_mem_arbiter.sv
// Two-master (fetch/data) arbiter onto a single word-wide memory port with
// bounded data-streak fairness, per-access timeout, and fully registered outputs.
module mips_mem_arbiter #(
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned MAX_STREAK = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [7:0] LP_TMO    = 8'(TIMEOUT);

  logic [1:0] r_state;
  logic [1:0] r_streak;
  logic [7:0] r_tmo;

  logic w_arb_ok;
  logic w_streak_ok;
  logic w_grant_d;
  logic w_grant_i;
  logic w_tmo_hit;

  // No grant while a done pulse is out: a requester still holding its level
  // request in that cycle is not mistaken for a fresh one.
  always_comb begin
    w_arb_ok    = (r_state == ST_IDLE) && !i_done && !d_done;
    w_streak_ok = 32'(r_streak) < MAX_STREAK;
    w_grant_d   = w_arb_ok && d_req && (!i_req || w_streak_ok);
    w_grant_i   = w_arb_ok && !w_grant_d && i_req;
    w_tmo_hit   = (r_tmo + 8'd1) == LP_TMO;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_streak  <= 2'd0;
      r_tmo     <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_err     <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_err  <= 1'b0;
      d_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state   <= ST_BUSY_D;
            r_tmo     <= 8'd0;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (i_req) r_streak <= (r_streak == 2'd3) ? 2'd3 : r_streak + 2'd1;
            else       r_streak <= 2'd0;
          end else if (w_grant_i) begin
            r_state   <= ST_BUSY_I;
            r_tmo     <= 8'd0;
            r_streak  <= 2'd0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= 32'd0;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // Ack has priority over a timeout landing on the same edge.
          if (mem_ack) begin
            r_state <= ST_IDLE;
            mem_req <= 1'b0;
            if (r_state == ST_BUSY_I) begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_done <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end
          end else if (w_tmo_hit) begin
            r_state <= ST_IDLE;
            mem_req <= 1'b0;
            if (r_state == ST_BUSY_I) begin
              i_done <= 1'b1;
              i_err  <= 1'b1;
            end else begin
              d_done <= 1'b1;
              d_err  <= 1'b1;
            end
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: inputs driven and outputs sampled on the
// falling edge, every expectation hand-computed.
module tb_mips_mem_arbiter;

  logic        clock;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  mips_mem_arbiter #(
    .TIMEOUT    (15),
    .MAX_STREAK (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          cnt;
    int          ngr;
    logic [31:0] got [6];
    logic [31:0] want_seq [6];

    want_seq = '{32'h200, 32'h200, 32'h100, 32'h200, 32'h200, 32'h100};
    got      = '{default: 32'h0};

    reset_n   = 1'b0;
    i_req     = 1'b0;
    i_addr    = 32'h0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_dones", {i_done, d_done, i_err, d_err}, 0);
    reset_n = 1'b1;

    // Single fetch, ack in the third mem_req cycle
    i_req  = 1'b1;
    i_addr = 32'h10;
    @(negedge clock);
    chk("f_req_c1", mem_req, 1);
    chk("f_we", mem_we, 0);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_wdata", mem_wdata, 0);
    @(negedge clock);
    chk("f_req_c2", mem_req, 1);
    @(negedge clock);
    chk("f_req_c3", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(negedge clock);
    chk("f_req_drop", mem_req, 0);
    chk("f_done", i_done, 1);
    chk("f_err", i_err, 0);
    chk("f_rdata", i_rdata, 32'hDEADBEEF);
    i_req     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clock);
    chk("f_done_pulse", i_done, 0);

    // Minimum-latency data load
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h20;
    @(negedge clock);
    chk("ld_req", mem_req, 1);
    chk("ld_addr", mem_addr, 32'h20);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clock);
    chk("ld_done", d_done, 1);
    chk("ld_rdata", d_rdata, 32'hCAFEF00D);
    chk("ld_req_drop", mem_req, 0);
    d_req   = 1'b0;
    mem_ack = 1'b0;
    @(negedge clock);

    // Store: latched fields stay put even if the requester's bus changes
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h4;
    d_wdata = 32'h12345678;
    @(negedge clock);
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 32'h4);
    chk("st_wdata", mem_wdata, 32'h12345678);
    d_addr  = 32'hFFFFFFF0;
    d_wdata = 32'h0;
    @(negedge clock);
    chk("st_we_hold", mem_we, 1);
    chk("st_addr_hold", mem_addr, 32'h4);
    chk("st_wdata_hold", mem_wdata, 32'h12345678);
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clock);
    chk("st_done", d_done, 1);
    chk("st_rdata_keep", d_rdata, 32'hCAFEF00D);
    chk("st_err", d_err, 0);
    d_req   = 1'b0;
    d_we    = 1'b0;
    mem_ack = 1'b0;
    @(negedge clock);

    // Stray ack while idle
    mem_ack   = 1'b1;
    mem_rdata = 32'h55555555;
    @(negedge clock);
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_done", {i_done, d_done}, 0);
    chk("idle_ack_rdata", d_rdata, 32'hCAFEF00D);
    mem_ack = 1'b0;
    @(negedge clock);

    // Fetch timeout with no ack
    i_req  = 1'b1;
    i_addr = 32'h40;
    @(negedge clock);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!mem_req) break;
      cnt++;
      @(negedge clock);
    end
    chk("to_cycles", cnt, 15);
    chk("to_done", i_done, 1);
    chk("to_err", i_err, 1);
    chk("to_rdata_keep", i_rdata, 32'hDEADBEEF);
    i_req = 1'b0;
    @(negedge clock);
    chk("to_err_pulse", i_err, 0);

    // Ack on the timeout edge completes normally
    i_req  = 1'b1;
    i_addr = 32'h44;
    @(negedge clock);
    chk("ato_req", mem_req, 1);
    repeat (14) @(negedge clock);
    chk("ato_req_c15", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    @(negedge clock);
    chk("ato_done", i_done, 1);
    chk("ato_err", i_err, 0);
    chk("ato_rdata", i_rdata, 32'h0BADF00D);
    i_req   = 1'b0;
    mem_ack = 1'b0;
    @(negedge clock);

    // Both requesters held, single-cycle acks
    i_addr    = 32'h100;
    d_addr    = 32'h200;
    d_we      = 1'b0;
    i_req     = 1'b1;
    d_req     = 1'b1;
    mem_rdata = 32'h77;
    ngr       = 0;
    for (int k = 0; k < 40 && ngr < 6; k++) begin
      @(negedge clock);
      if (mem_req) begin
        got[ngr] = mem_addr;
        ngr++;
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
    end
    @(negedge clock);
    i_req   = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    chk("arb_ngrants", ngr, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("arb_grant%0d", k), got[k], want_seq[k]);
    repeat (2) @(negedge clock);

    // Reset in the middle of a data access
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h300;
    i_req  = 1'b1;
    i_addr = 32'h400;
    @(negedge clock);
    chk("rm_req", mem_req, 1);
    chk("rm_addr", mem_addr, 32'h300);
    #2 reset_n = 1'b0;
    #1;
    chk("rm_async_req", mem_req, 0);
    chk("rm_async_addr", mem_addr, 0);
    d_req = 1'b0;
    @(negedge clock);
    chk("rm_no_done", {d_done, d_err}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rm_regrant_req", mem_req, 1);
    chk("rm_regrant_addr", mem_addr, 32'h400);
    chk("rm_no_done2", d_done, 0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h600D;
    @(negedge clock);
    chk("rm_i_done", i_done, 1);
    chk("rm_i_rdata", i_rdata, 32'h600D);
    i_req   = 1'b0;
    mem_ack = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, 15: no-ack cycles in a busy state before abort (legal range 1..255).
REQ-002 Parameter MAX_STREAK, 2: consecutive data grants allowed while fetch is waiting.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_req  input  1  fetch request, level; held until i_done.
REQ-006 i_addr  input  32  fetch word address.
REQ-007 i_rdata  output  32  fetch read data.
REQ-008 i_done  output  1  one-cycle fetch completion pulse.
REQ-009 i_err  output  1  one-cycle fetch timeout pulse.
REQ-010 d_req  input  1  data request, level; held until d_done.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  32  data word address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_rdata  output  32  load data.
REQ-015 d_done  output  1  one-cycle data completion pulse.
REQ-016 d_err  output  1  one-cycle data timeout pulse.
REQ-017 mem_req  output  1  memory access strobe.
REQ-018 mem_we  output  1  memory write enable.
REQ-019 mem_addr  output  32  memory word address.
REQ-020 mem_wdata  output  32  memory write data.
REQ-021 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-022 mem_ack  input  1  memory completion, sampled only while mem_req is high.

Function
REQ-023 The arbiter SHALL use states IDLE, BUSY_I and BUSY_D; every output SHALL be registered.
REQ-024 Arbitration in IDLE:
- Data wins when d_req=1 and (i_req=0 or streak<MAX_STREAK).
- Otherwise fetch wins when i_req=1.
- Otherwise the arbiter stays in IDLE.
REQ-025 A requester whose done pulse is high in the current cycle SHALL be masked from that cycle's arbitration.
REQ-026 On a grant at edge N, the arbiter SHALL latch mem_addr, mem_we (0 for fetch) and mem_wdata (0 for fetch).
- mem_req SHALL be high from cycle N+1.
- mem_addr, mem_we and mem_wdata SHALL stay constant while mem_req is high.
REQ-027 Streak counter (2 bits, saturating):
- Increments on a data grant when i_req=1.
- Clears to 0 on a data grant when i_req=0.
- Clears to 0 on a fetch grant.
REQ-028 When mem_ack=1 at edge M in a busy state:
- mem_req SHALL drop in cycle M+1.
- The owner's done SHALL pulse in cycle M+1.
- For reads only, the owner's rdata SHALL capture mem_rdata.
- The state SHALL return to IDLE.
REQ-029 Minimum latency SHALL be 2 cycles: request sampled at edge N, ack at edge N+1, done high in cycle N+2.
REQ-030 The timeout counter (8 bits) SHALL clear on grant and increment each busy cycle without ack.
- When it reaches TIMEOUT, mem_req SHALL drop.
- Done and err SHALL pulse together for the owner, rdata SHALL be unchanged, and the state SHALL return to IDLE.
REQ-031 If mem_ack arrives on the same edge the counter reaches TIMEOUT, the ack SHALL win (normal completion, no err).
REQ-032 mem_ack SHALL be ignored in IDLE.
REQ-033 A write SHALL never alter d_rdata; i_rdata and d_rdata SHALL hold their values between completions.
REQ-034 A request dropped before done is a protocol violation: the transaction in flight SHALL still complete, and done SHALL still pulse.

Reset
REQ-035 While reset_n=0, immediately and regardless of clock:
- State = IDLE; streak and timeout counters = 0.
- All outputs = 0: mem_req, mem_we, mem_addr, mem_wdata, i/d_rdata, i/d_done, i/d_err.
REQ-036 Reset during a busy state SHALL abort the access without a done or err pulse; the first grant is possible at the first clock edge with reset_n=1.

Verification
REQ-037 Single fetch: i_req, i_addr=0x10; ack with mem_rdata=0xDEADBEEF after 3 cycles -> mem_req high for 3 cycles, mem_we=0, i_done one cycle, i_rdata=0xDEADBEEF.
REQ-038 Simultaneous requests: i_req and d_req both held, 1-cycle ack each -> grant order D, D, I, D, D, I; streak never exceeds 2.
REQ-039 Store: d_we=1, d_addr=0x4, d_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678 stable until ack; d_done pulses; d_rdata unchanged.
REQ-040 Timeout: fetch with no ack, TIMEOUT=15 -> mem_req drops after 15 busy cycles; i_done and i_err pulse together; i_rdata unchanged.
REQ-041 Ack on the timeout edge -> normal completion, i_err=0.
REQ-042 Reset mid-transaction: assert reset_n=0 during BUSY_D -> mem_req=0 immediately, no d_done; after release, a pending i_req is granted at the first edge.
